// File: rtl/frame_spill_fill.sv
// Spills a 15-word register frame to memory on save and refills it on restore, then pulses restore.
// Latency: save = 16 cycles, fill = 17 cycles with zero-wait acks; a low mem_ack holds the current word and adds one cycle.
module frame_spill_fill #(
    parameter int NREGS   = 15,
    parameter int WIDTH   = 16,
    parameter int FRAME_W = NREGS * WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               save_req,
    input  logic               restore_req,
    input  logic [WIDTH-1:0]   base_addr,
    input  logic [FRAME_W-1:0] fc_snapshot,
    output logic [FRAME_W-1:0] fc_image,
    output logic               restore_pulse,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   frame_end,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic               mem_ack,
    input  logic [WIDTH-1:0]   mem_rdata
);

    localparam int IW = $clog2(NREGS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        FILL,
        APPLY,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [WIDTH-1:0]   base, base_n;
    logic [FRAME_W-1:0] shadow, shadow_n;
    logic [WIDTH-1:0]   frame_end_q, frame_end_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            base        <= '0;
            shadow      <= '0;
            frame_end_q <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            base        <= base_n;
            shadow      <= shadow_n;
            frame_end_q <= frame_end_n;
        end
    end

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        base_n        = base;
        shadow_n      = shadow;
        frame_end_n   = frame_end_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        restore_pulse = 1'b0;
        done          = 1'b0;
        busy          = (state != IDLE);

        case (state)
            IDLE: begin
                // Save has priority; a coincident restore is dropped, not queued.
                if (save_req || restore_req) begin
                    base_n      = base_addr;
                    idx_n       = '0;
                    frame_end_n = base_addr + WIDTH'(NREGS);
                    if (save_req) begin
                        shadow_n = fc_snapshot;
                        state_n  = SAVE;
                    end else begin
                        state_n  = FILL;
                    end
                end
            end
            SAVE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base + WIDTH'(idx);
                mem_wdata = shadow[idx*WIDTH +: WIDTH];
                if (mem_ack) begin
                    if (idx == LAST_IDX) state_n = DONE;
                    else                 idx_n   = idx + 1'b1;
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = base + WIDTH'(idx);
                if (mem_ack) begin
                    shadow_n[idx*WIDTH +: WIDTH] = mem_rdata;
                    if (idx == LAST_IDX) state_n = APPLY;
                    else                 idx_n   = idx + 1'b1;
                end
            end
            APPLY: begin
                restore_pulse = 1'b1;
                state_n       = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign fc_image  = shadow;
    assign frame_end = frame_end_q;

endmodule

// File: doc/frame_spill_fill.md
Name: frame_spill_fill

Overview:
- Memory-side partner of the register management system's function-call frame port.
- On a call (save), it snapshots the 240-bit frame (15 x 16-bit registers) from the regfile's fcOut and writes it word by word to data memory.
- On a return (fill), it reads the 15 words back, assembles the 240-bit fcIn image, then pulses the regfile's restore input for one cycle.
- Sits between the RMS frame port and the data-memory arbiter.

Parameters:
- NREGS, 15, number of frame words.
- WIDTH, 16, word width in bits.
- FRAME_W, 240, NREGS*WIDTH; must match the fcIn/fcOut width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- save_req  in  1  single-cycle request: spill the frame.
- restore_req  in  1  single-cycle request: fill the frame.
- base_addr  in  16  frame base address, sampled when a request is accepted.
- fc_snapshot  in  240  connected to the RMS fcOut.
- fc_image  out  240  connected to the RMS fcIn.
- restore_pulse  out  1  connected to the RMS restore input.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an operation completes.
- frame_end  out  16  base + NREGS, latched at accept; next free address.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  16  word address.
- mem_wdata  out  16  write data.
- mem_ack  in  1  request completes this cycle; may be asserted in the same cycle as mem_req.
- mem_rdata  in  16  read data, valid when mem_ack is high and mem_we is low.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state = IDLE, idx = 0, shadow = 0.
  - mem_req, mem_we, restore_pulse, done, busy = 0.
  - mem_addr, mem_wdata, frame_end = 0.
  - Reset mid-operation aborts immediately; no further memory cycles are issued.
- States: IDLE, SAVE, FILL, APPLY, DONE.
- IDLE:
  - save_req high -> latch fc_snapshot into shadow, base = base_addr, idx = 0, frame_end = base_addr + 15 (mod 2^16), go to SAVE.
  - Otherwise restore_req high -> same latching except the shadow is not loaded; go to FILL.
  - Both high in the same cycle -> save wins; the restore request is dropped.
- SAVE:
  - mem_req = 1, mem_we = 1, mem_addr = base + idx (mod 2^16), mem_wdata = shadow[16*idx+15 : 16*idx].
  - On mem_ack: if idx == 14, go to DONE; otherwise increment idx.
  - Without mem_ack: all outputs held stable.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = base + idx.
  - On mem_ack: shadow[16*idx+15 : 16*idx] = mem_rdata.
  - If idx == 14, go to APPLY; otherwise increment idx.
- APPLY:
  - restore_pulse = 1 for exactly one cycle, mem_req = 0, then go to DONE.
- DONE:
  - done = 1 for one cycle, then go to IDLE.
- fc_image:
  - Always driven from the shadow register.
  - Stable throughout APPLY.
  - After a save it holds the saved frame.
- Address arithmetic is 16-bit wrap-around: base 0xFFF8 writes 0xFFF8 through 0x0006.
- save_req and restore_req are ignored while busy; requests are not queued.
- fc_snapshot changes after the accept cycle do not affect the spilled data.
- Latency with zero-wait acks (mem_ack tied high):
  - Save accepted at cycle T: writes occur at T+1..T+15, done at T+16.
  - Fill accepted at cycle T: reads occur at T+1..T+15, restore_pulse at T+16, done at T+17.
- Each wait cycle (mem_ack low) adds one cycle.
- mem_req never drops between words of the same operation.

Test Plan:
- Save, zero-wait: fc_snapshot word i = 0x1000+i, base_addr = 0x0200, save_req pulse -> writes 0x0200..0x020E with data 0x1000..0x100E in order; done at T+16; frame_end = 0x020F; restore_pulse never asserted.
- Fill with random mem_ack stalls (ack prob 0.5): memory word at 0x0300+i = 0xA000+i -> fc_image[16*i+15:16*i] = 0xA000+i; restore_pulse high exactly one cycle; done on the following cycle; fc_image unchanged during stalls.
- Round trip: save a random frame to 0x4000, corrupt fc_snapshot, fill from 0x4000 -> fc_image equals the original frame bit for bit.
- Simultaneous save_req and restore_req in IDLE -> save performed only (mem_we = 1 on all 15 cycles); a save_req issued mid-operation -> ignored, exactly 15 memory cycles.
- Wrap-around: base_addr = 0xFFFA, save -> addresses 0xFFFA..0xFFFF then 0x0000..0x0008; frame_end = 0x0009.
- Reset asserted at word 7 of a fill -> next cycle: busy = 0, mem_req = 0, fc_image = 0, no restore_pulse or done; a new save afterwards completes normally.
